// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment display blocks:
//   - SEG_* : active-low segment patterns {dp,g,f,e,d,c,b,a}, dp off
//   - SEG_OFF / DIGIT_OFF : all segments / all digit enables released
//   - state_t : scan FSM states
//   - disp_cfg_t : one displayable update (value, dp, blank, lz_en)
//   - hex_to_seg() : nibble -> segment pattern lookup
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [7:0] SEG_0   = 8'hC0;
  localparam logic [7:0] SEG_1   = 8'hF9;
  localparam logic [7:0] SEG_2   = 8'hA4;
  localparam logic [7:0] SEG_3   = 8'hB0;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h92;
  localparam logic [7:0] SEG_6   = 8'h82;
  localparam logic [7:0] SEG_7   = 8'hF8;
  localparam logic [7:0] SEG_8   = 8'h80;
  localparam logic [7:0] SEG_9   = 8'h90;
  localparam logic [7:0] SEG_A   = 8'h88;
  localparam logic [7:0] SEG_B   = 8'h83;
  localparam logic [7:0] SEG_C   = 8'hC6;
  localparam logic [7:0] SEG_D   = 8'hA1;
  localparam logic [7:0] SEG_E   = 8'h86;
  localparam logic [7:0] SEG_F   = 8'h8E;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [3:0] DIGIT_OFF = 4'b1111;

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } state_t;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz_en;
  } disp_cfg_t;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0:    hex_to_seg = SEG_0;
      4'h1:    hex_to_seg = SEG_1;
      4'h2:    hex_to_seg = SEG_2;
      4'h3:    hex_to_seg = SEG_3;
      4'h4:    hex_to_seg = SEG_4;
      4'h5:    hex_to_seg = SEG_5;
      4'h6:    hex_to_seg = SEG_6;
      4'h7:    hex_to_seg = SEG_7;
      4'h8:    hex_to_seg = SEG_8;
      4'h9:    hex_to_seg = SEG_9;
      4'hA:    hex_to_seg = SEG_A;
      4'hB:    hex_to_seg = SEG_B;
      4'hC:    hex_to_seg = SEG_C;
      4'hD:    hex_to_seg = SEG_D;
      4'hE:    hex_to_seg = SEG_E;
      default: hex_to_seg = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl_if
// Application-side update bus of the scan controller.
//   value[15:0]  : hex value, digit k shows value[4k-1:4k-4]
//   dp[3:0]      : decimal point per digit, active-high
//   blank[3:0]   : force digit off, active-high
//   lz_en        : leading-zero suppression enable
//   load         : one-cycle strobe capturing the four fields above
//   busy         : a captured update is waiting for the next frame boundary
//   frame_done   : one-cycle pulse after each frame boundary
// master = application logic, slave = seg7_scan_ctrl.
// -----------------------------------------------------------------------------
interface seg7_scan_ctrl_if;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_en;
  logic        load;
  logic        busy;
  logic        frame_done;

  modport master (
    output value, dp, blank, lz_en, load,
    input  busy, frame_done
  );

  modport slave (
    input  value, dp, blank, lz_en, load,
    output busy, frame_done
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Combinational hex nibble to active-low 7-segment pattern.
//   i_nibble[3:0] : hex digit
//   i_dp          : decimal point on (active-high)
//   i_blank       : force all segments off, including dp
//   o_seg[7:0]    : active-low segments, [7]=dp, [6:0]=g..a
// -----------------------------------------------------------------------------
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_seg = SEG_OFF;
    if (!i_blank) begin
      o_seg    = hex_to_seg(i_nibble);
      o_seg[7] = ~i_dp;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment
// display. Each digit slot is DIV = CLK_HZ/SCAN_HZ cycles: a SHOW phase
// driving one digit, then DEAD_CYCLES blanked GAP cycles to avoid ghosting.
// Updates are double-buffered: load captures into a pending set, which moves
// to the displayed shadow set only at the frame boundary (last GAP cycle of
// digit 4), so a frame never mixes old and new values.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : update bus (seg7_scan_ctrl_if.slave)
//   digit[4:1] : digit enables, active-low, one-cold or all-ones
//   data[7:0]  : segments, active-low, [7]=dp, [6:0]=g..a
// All outputs are registered. DIV >= DEAD_CYCLES + 2 is required.
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic              clk,
  input  logic              rst,
  seg7_scan_ctrl_if.slave   bus,
  output logic [4:1]        digit,
  output logic [7:0]        data
);

  localparam int DIV  = CLK_HZ / SCAN_HZ;
  localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST_SHOW = CW'(DIV - DEAD_CYCLES - 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(DIV - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;          // 0..3 selects digit 1..4
  disp_cfg_t     r_pend;
  disp_cfg_t     r_shad;
  logic          r_busy;
  logic          r_frame_done;
  logic [3:0]    r_digit;
  logic [7:0]    r_data;

  logic          w_slot_end;
  logic          w_boundary;
  logic [3:0]    w_lz;
  logic [3:0]    w_nibble;
  logic [7:0]    w_seg;
  logic [3:0]    w_digit_nxt;
  logic [7:0]    w_data_nxt;

  assign w_slot_end = (r_state == GAP) && (r_cnt == LAST_CNT);
  assign w_boundary = w_slot_end && (r_idx == 2'd3);

  // Leading-zero suppression: a digit goes dark when it and every higher
  // nibble are zero. Digit 1 always shows, and a lit dp keeps its digit on.
  assign w_lz[0] = 1'b0;
  assign w_lz[1] = r_shad.lz_en & ~r_shad.dp[1] & (r_shad.value[15:4]  == 12'h000);
  assign w_lz[2] = r_shad.lz_en & ~r_shad.dp[2] & (r_shad.value[15:8]  == 8'h00);
  assign w_lz[3] = r_shad.lz_en & ~r_shad.dp[3] & (r_shad.value[15:12] == 4'h0);

  assign w_nibble = r_shad.value[{r_idx, 2'b00} +: 4];

  seg7_hex_decode u_decode (
    .i_nibble (w_nibble),
    .i_dp     (r_shad.dp[r_idx]),
    .i_blank  (r_shad.blank[r_idx] | w_lz[r_idx]),
    .o_seg    (w_seg)
  );

  // Next state and next (pre-register) display outputs.
  always_comb begin
    w_next_state = r_state;
    w_digit_nxt  = DIGIT_OFF;
    w_data_nxt   = SEG_OFF;
    case (r_state)
      SHOW: begin
        w_digit_nxt = ~(4'b0001 << r_idx);
        w_data_nxt  = w_seg;
        if (r_cnt == LAST_SHOW) w_next_state = GAP;
      end
      GAP: begin
        if (r_cnt == LAST_CNT) w_next_state = SHOW;
      end
      default: w_next_state = SHOW;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= SHOW;
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_pend       <= '0;
      r_shad       <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_digit      <= DIGIT_OFF;
      r_data       <= SEG_OFF;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
      if (w_slot_end) r_idx <= r_idx + 2'd1;

      r_digit      <= w_digit_nxt;
      r_data       <= w_data_nxt;
      r_frame_done <= w_boundary;

      // At the boundary the old pending set goes live; a load on that same
      // cycle refills pending and keeps busy set for the following frame.
      if (w_boundary) begin
        r_shad <= r_pend;
        r_busy <= bus.load;
      end else if (bus.load) begin
        r_busy <= 1'b1;
      end

      if (bus.load) r_pend <= {bus.value, bus.dp, bus.blank, bus.lz_en};
    end
  end

  assign digit          = r_digit;
  assign data           = r_data;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Self-checking bench for seg7_scan_ctrl with DIV=8, DEAD_CYCLES=2.
// A frame-position model (cycle count modulo the frame length plus pending /
// shown update sets) predicts digit, data, busy and frame_done every cycle.
// A vector table of updates with hand-computed per-digit patterns, a few
// hand-written sequences and random loads drive the design.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int DIV  = 8;
  localparam int DEAD = 2;
  localparam int F    = 4 * DIV;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz;
  } cfg_t;

  typedef struct packed {
    cfg_t        cfg;
    logic [31:0] exp;   // {digit4, digit3, digit2, digit1} segment bytes
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:1] digit;
  logic [7:0] data;

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(
    .CLK_HZ      (8000),
    .SCAN_HZ     (1000),
    .DEAD_CYCLES (DEAD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .digit (digit),
    .data  (data)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  cfg_t        m_pend;
  cfg_t        m_shad;
  logic        m_busy;
  int          m_n;
  logic [7:0]  glyph [16];
  logic [7:0]  obs   [4];
  vec_t        vecs  [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_seg(input cfg_t c, input int k);
    logic [15:0] upper;
    logic [7:0]  s;
    upper = c.value >> (4 * (k - 1));
    if (c.blank[k-1]) return 8'hFF;
    if (c.lz && k > 1 && !c.dp[k-1] && upper == 16'h0) return 8'hFF;
    s = glyph[upper[3:0]];
    if (c.dp[k-1]) s[7] = 1'b0;
    return s;
  endfunction

  task automatic model_reset();
    m_n    = 0;
    m_pend = '0;
    m_shad = '0;
    m_busy = 1'b0;
  endtask

  // One clock: predict outputs from the frame position, advance the model,
  // compare #1 after the edge.
  task automatic step();
    logic       ld;
    cfg_t       in;
    int         p, slot, pos;
    logic [3:0] e_dig;
    logic [7:0] e_dat;
    logic       e_fd;
    ld = bus.load;
    in = {bus.value, bus.dp, bus.blank, bus.lz_en};
    @(posedge clk);
    p    = m_n % F;
    slot = p / DIV;
    pos  = p % DIV;
    if (pos < DIV - DEAD) begin
      e_dig = 4'(~(1 << slot));
      e_dat = exp_seg(m_shad, slot + 1);
    end else begin
      e_dig = 4'b1111;
      e_dat = 8'hFF;
    end
    e_fd = (p == F - 1);
    if (e_fd) begin
      m_shad = m_pend;
      m_busy = ld;
    end else if (ld) begin
      m_busy = 1'b1;
    end
    if (ld) m_pend = in;
    m_n++;
    #1;
    check("cycle", {digit, data, bus.busy, bus.frame_done}, {e_dig, e_dat, m_busy, e_fd});
  endtask

  task automatic do_load(input cfg_t c);
    bus.value = c.value;
    bus.dp    = c.dp;
    bus.blank = c.blank;
    bus.lz_en = c.lz;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
  endtask

  // Step until the next edge is at frame position p.
  task automatic advance_to(input int p);
    while (m_n % F != p) step();
  endtask

  task automatic wait_frame();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < F + 2 && !seen; i++) begin
      step();
      if (bus.frame_done) seen = 1'b1;
    end
    check("frame_done seen", seen, 1);
  endtask

  task automatic observe_frame();
    for (int k = 0; k < 4; k++) obs[k] = 8'h5A;
    for (int i = 0; i < F; i++) begin
      step();
      case (digit)
        4'b1110: obs[0] = data;
        4'b1101: obs[1] = data;
        4'b1011: obs[2] = data;
        4'b0111: obs[3] = data;
        default: ;
      endcase
    end
  endtask

  task automatic check_frame(input string name, input logic [31:0] exp);
    for (int k = 0; k < 4; k++) check(name, obs[k], exp[8*k +: 8]);
  endtask

  initial begin
    glyph = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    vecs[0] = '{'{16'h1A3F, 4'b0010, 4'b0000, 1'b0}, 32'hF988308E};
    vecs[1] = '{'{16'h0050, 4'b0000, 4'b0000, 1'b1}, 32'hFFFF92C0};
    vecs[2] = '{'{16'h0000, 4'b0000, 4'b0000, 1'b1}, 32'hFFFFFFC0};
    vecs[3] = '{'{16'h1234, 4'b1111, 4'b1001, 1'b0}, 32'hFF2430FF};
    vecs[4] = '{'{16'h0800, 4'b0000, 4'b0000, 1'b1}, 32'hFF80C0C0};
    vecs[5] = '{'{16'h0007, 4'b0100, 4'b0000, 1'b1}, 32'hFF40FFF8};
    vecs[6] = '{'{16'h9CDE, 4'b0000, 4'b0000, 1'b0}, 32'h90C6A186};
    vecs[7] = '{'{16'h46B5, 4'b0000, 4'b0000, 1'b1}, 32'h99828392};

    rst       = 1'b1;
    bus.value = '0;
    bus.dp    = '0;
    bus.blank = '0;
    bus.lz_en = 1'b0;
    bus.load  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset digit", digit, 4'b1111);
    check("reset data", data, 8'hFF);
    check("reset busy", bus.busy, 0);
    check("reset frame_done", bus.frame_done, 0);
    rst = 1'b0;
    model_reset();

    // Free-running scan after reset, all zeros shown.
    step();
    check("first digit", digit, 4'b1110);
    check("first data", data, 8'hC0);
    for (int i = 0; i < 2 * F; i++) step();

    // Table of updates: load mid-frame, shown in the frame after the boundary.
    for (int i = 0; i < 8; i++) begin
      advance_to(10);
      do_load(vecs[i].cfg);
      check("busy after load", bus.busy, 1);
      wait_frame();
      check("busy cleared", bus.busy, 0);
      observe_frame();
      check_frame($sformatf("vec%0d digit", i), vecs[i].exp);
    end

    // Two loads in one frame: the last one wins.
    advance_to(5);
    do_load('{16'h1234, 4'b0000, 4'b0000, 1'b0});
    advance_to(20);
    do_load('{16'h5678, 4'b0000, 4'b0000, 1'b0});
    wait_frame();
    observe_frame();
    check_frame("last load wins", 32'h9282F880);

    // Load on the boundary cycle: earlier pending goes live, new one waits.
    advance_to(10);
    do_load('{16'h00C3, 4'b0000, 4'b0000, 1'b0});
    advance_to(F - 1);
    do_load('{16'h9E00, 4'b0000, 4'b0000, 1'b0});
    check("busy held at boundary load", bus.busy, 1);
    check("frame_done at boundary load", bus.frame_done, 1);
    observe_frame();
    check_frame("prior pending shown", 32'hC0C0C6B0);
    check("busy after deferred frame", bus.busy, 0);
    observe_frame();
    check_frame("boundary load shown", 32'h9086C0C0);

    // Reset during digit 3 SHOW with an update pending.
    advance_to(2 * DIV + 1);
    do_load('{16'h4321, 4'b0000, 4'b0000, 1'b0});
    step();
    #2 rst = 1'b1;
    #1;
    check("mid reset digit", digit, 4'b1111);
    check("mid reset data", data, 8'hFF);
    check("mid reset busy", bus.busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    step();
    check("restart digit", digit, 4'b1110);
    check("restart data", data, 8'hC0);
    for (int i = 0; i < 2 * F; i++) step();

    // Random loads against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        cfg_t c;
        c.value = 16'($urandom) >> $urandom_range(0, 15);
        c.dp    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
        c.blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
        c.lz    = 1'($urandom);
        do_load(c);
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
